result_bcd_converter: RTL and testbench
=======================================

RESULT_BCD_CONVERTER -- requirements
Module: result_bcd_converter

Interface
REQ-001 Parameter WIDTH, default 32, SHALL be the binary input width in bits.
REQ-002 Parameter DIGITS, default 10, SHALL be the number of BCD output digits, sufficient for 2^WIDTH-1.
REQ-003 Parameter SIGNED, default 1, SHALL select whether value is two's complement (1) or unsigned (0).
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-006 Port start, input, 1 bit, SHALL request a conversion of value.
REQ-007 Port value, input, WIDTH bits, SHALL be the CPU result to convert; it is sampled only on an accepted start.
REQ-008 Port busy, output, 1 bit, SHALL be high while a conversion is in progress, including the done cycle.
REQ-009 Port done, output, 1 bit, SHALL be a one-cycle pulse marking new valid results.
REQ-010 Port negative, output, 1 bit, SHALL be the sign of the converted value.
REQ-011 Port bcd, output, 4*DIGITS bits, SHALL hold the magnitude; digit 0 (units) is in bits [3:0].
REQ-012 Port num_digits, output, 4 bits, SHALL be the count of significant digits, 1..DIGITS.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-014 In IDLE, start=1 SHALL be accepted, which:
- latches the magnitude (absolute value when SIGNED=1 and value[WIDTH-1]=1, else value) and the sign;
- clears the BCD scratch register;
- loads the iteration counter with WIDTH-1;
- moves the FSM to SHIFT.
REQ-015 The magnitude register SHALL be WIDTH bits unsigned, so the most negative input (0x80000000 at WIDTH=32) yields magnitude 2147483648 without overflow.
REQ-016 Each SHIFT cycle SHALL perform one double-dabble step.
- First add 3 to every scratch digit >= 5.
- Then shift {scratch, magnitude} left by one.
REQ-017 SHIFT SHALL last exactly WIDTH cycles; when the counter reaches 0 the FSM SHALL go to DONE.
REQ-018 In DONE the following SHALL happen, then the FSM SHALL return to IDLE next cycle:
- done=1 for exactly that cycle;
- bcd, negative and num_digits update to the new results.
REQ-019 Latency: done SHALL assert exactly WIDTH+1 cycles after the edge that sampled start (33 at default).
REQ-020 bcd, negative and num_digits SHALL hold their values between done pulses, and SHALL NOT change at any other time.
REQ-021 start SHALL be ignored while busy=1, including the DONE cycle; no queuing.
REQ-022 num_digits SHALL equal 1 + index of the most significant nonzero digit, or 1 when the magnitude is zero.
REQ-023 negative SHALL be 0 whenever SIGNED=0 or the magnitude is zero.
REQ-024 busy SHALL be high in SHIFT and DONE and low in IDLE.

Reset
REQ-025 When reset=1 at a rising edge, the block SHALL apply the following, with reset winning over a simultaneous start:
- FSM to IDLE;
- busy=0, done=0, negative=0, bcd=0, num_digits=1;
- counter and scratch cleared.
REQ-026 Reset during SHIFT SHALL abort the conversion; no done pulse SHALL follow.

Structure
REQ-027 Package calc_pkg SHALL hold the following, shared with the display and top level:
- the conversion state enum (IDLE, SHIFT, DONE);
- the DIGITS default;
- the calculator op-code constants (0 add, 1 sub, 2 mul, 3 div, 4 pow).
REQ-028 A combinational sub-module bcd_digit_adjust (4-bit in, 4-bit out: +3 when >= 5) SHALL be instantiated once per digit via generate.

Verification
REQ-029 value=0 with a start pulse -> at cycle 33: done=1, bcd=0, num_digits=1, negative=0.
REQ-030 value=0xFFFFFFFF, SIGNED=1 -> bcd digits 0000000001, negative=1, num_digits=1.
REQ-031 value=0x80000000, SIGNED=1 -> bcd 2147483648 (0x2147483648), negative=1, num_digits=10.
REQ-032 value=255, then start re-pulsed at cycles 5 and 33 (during busy) -> exactly one done at cycle 33, bcd=0x255, num_digits=3, no second done.
REQ-033 Converting 255, then a start with value=7 and reset=1 asserted at cycle 10 -> reset clears all outputs, no done ever follows, busy=0 from cycle 11.
REQ-034 SIGNED=0 with value=0xFFFFFFFF -> bcd 4294967295, negative=0, num_digits=10.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: conversion FSM states, display digit count,
// and arithmetic op-code constants used by the display and top level.
`timescale 1ns/1ps
package calc_pkg;

  // Binary-to-BCD conversion states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // Enough decimal digits for a 32-bit magnitude (4294967295)
  localparam int unsigned DIGITS_DEFAULT = 10;

  // Calculator op-codes
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_POW = 3'd4;

endpackage : calc_pkg

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more so
// the following left shift carries correctly into the next decimal digit.
// Ports:
//   digit      - current 4-bit BCD digit
//   adjusted_c - corrected digit (combinational)
`timescale 1ns/1ps
module bcd_digit_adjust (
  input  logic [3:0] digit,
  output logic [3:0] adjusted_c
);

  assign adjusted_c = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule : bcd_digit_adjust

// File: rtl/result_bcd_converter.sv
// Sequential binary-to-BCD converter for CPU results (double dabble, one bit
// per clock). Signed inputs are converted as sign + magnitude.
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous active-high reset
//   start      - request conversion of value (accepted only when idle)
//   value      - binary result, sampled on an accepted start
//   busy       - high from acceptance through the done cycle
//   done       - one-cycle pulse when new results are presented
//   negative   - sign of the converted value (0 for zero / unsigned)
//   bcd        - magnitude digits, units in [3:0]
//   num_digits - count of significant digits, 1..DIGITS
`timescale 1ns/1ps
module result_bcd_converter
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = DIGITS_DEFAULT,
  parameter bit          SIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic                  negative,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [3:0]            num_digits
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned BCD_W = 4 * DIGITS;

  conv_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [BCD_W-1:0]   scr_q, scr_d;
  logic               sign_q, sign_d;
  logic               busy_d, done_d, neg_d;
  logic [BCD_W-1:0]   bcd_d;
  logic [3:0]         ndig_d;
  logic [BCD_W-1:0]   scr_adj_c;
  logic [BCD_W-1:0]   scr_shift_c;
  logic               in_neg_c;

  // 1 + index of the most significant nonzero digit, minimum 1
  function automatic logic [3:0] count_digits(input logic [BCD_W-1:0] d);
    logic [3:0] n;
    n = 4'd1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] != 4'd0) n = 4'(i + 1);
    end
    return n;
  endfunction

  // Per-digit +3 correction ahead of each shift
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit      (scr_q[4*g +: 4]),
      .adjusted_c (scr_adj_c[4*g +: 4])
    );
  end

  // Shift {scratch, magnitude} left by one
  assign scr_shift_c = {scr_adj_c[BCD_W-2:0], mag_q[WIDTH-1]};
  assign in_neg_c    = SIGNED && value[WIDTH-1];

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    scr_d   = scr_q;
    sign_d  = sign_q;
    bcd_d   = bcd;
    neg_d   = negative;
    ndig_d  = num_digits;

    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d  = in_neg_c;
          // Unsigned WIDTH-bit negate: most negative input maps to 2^(WIDTH-1)
          mag_d   = in_neg_c ? (~value) + WIDTH'(1) : value;
          scr_d   = '0;
          cnt_d   = CNT_W'(WIDTH - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = scr_shift_c;
        mag_d = {mag_q[WIDTH-2:0], 1'b0};
        if (cnt_q == '0) begin
          // Final step: publish results as the FSM enters DONE
          state_d = DONE;
          bcd_d   = scr_shift_c;
          neg_d   = sign_q && (scr_shift_c != '0);
          ndig_d  = count_digits(scr_shift_c);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mag_q      <= '0;
      scr_q      <= '0;
      sign_q     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      negative   <= 1'b0;
      bcd        <= '0;
      num_digits <= 4'd1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      scr_q      <= scr_d;
      sign_q     <= sign_d;
      busy       <= busy_d;
      done       <= done_d;
      negative   <= neg_d;
      bcd        <= bcd_d;
      num_digits <= ndig_d;
    end
  end

endmodule : result_bcd_converter

// File: tb/tb_result_bcd_converter.sv
// Directed bench for result_bcd_converter: a signed and an unsigned instance
// driven with hand-computed vectors. Cycle 1 is the period after the edge
// that samples start; done is expected in cycle 33.
`timescale 1ns/1ps
module tb_result_bcd_converter;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_start, u_start;
  logic [31:0] s_value, u_value;
  logic        s_busy, s_done, s_neg, u_busy, u_done, u_neg;
  logic [39:0] s_bcd, u_bcd;
  logic [3:0]  s_ndig, u_ndig;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  result_bcd_converter #(.WIDTH(32), .DIGITS(10), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .reset(reset), .start(s_start), .value(s_value),
    .busy(s_busy), .done(s_done), .negative(s_neg), .bcd(s_bcd),
    .num_digits(s_ndig)
  );

  result_bcd_converter #(.WIDTH(32), .DIGITS(10), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .reset(reset), .start(u_start), .value(u_value),
    .busy(u_busy), .done(u_done), .negative(u_neg), .bcd(u_bcd),
    .num_digits(u_ndig)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Start one conversion; return the cycle done was seen (-1 on timeout),
  // then step one more cycle so the FSM is back in IDLE.
  task automatic run_conv(input bit uns, input logic [31:0] v, output int dcyc);
    dcyc = -1;
    if (uns) begin u_start = 1'b1; u_value = v; end
    else     begin s_start = 1'b1; s_value = v; end
    @(negedge clk);
    s_start = 1'b0;
    u_start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if ((uns ? u_done : s_done) === 1'b1) begin
        dcyc = c;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  int dc;
  int n_done, done_at, busy_after;

  initial begin
    reset = 1'b1; s_start = 1'b0; u_start = 1'b0; s_value = '0; u_value = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(s_busy), 64'd0);
    check("rst_done", 64'(s_done), 64'd0);
    check("rst_bcd",  64'(s_bcd),  64'd0);
    check("rst_neg",  64'(s_neg),  64'd0);
    check("rst_ndig", 64'(s_ndig), 64'd1);
    reset = 1'b0;
    @(negedge clk);

    // Zero
    s_start = 1'b1; s_value = 32'd0;
    @(negedge clk);
    s_start = 1'b0;
    dc = -1;
    for (int c = 1; c <= 60; c++) begin
      if (c == 1) check("zero_busy_c1", 64'(s_busy), 64'd1);
      if (s_done === 1'b1) begin
        dc = c;
        check("zero_busy_done", 64'(s_busy), 64'd1);
        break;
      end
      @(negedge clk);
    end
    check("zero_cycle", 64'(dc), 64'd33);
    check("zero_bcd",   64'(s_bcd),  64'd0);
    check("zero_ndig",  64'(s_ndig), 64'd1);
    check("zero_neg",   64'(s_neg),  64'd0);
    @(negedge clk);
    check("zero_idle_busy", 64'(s_busy), 64'd0);
    check("zero_idle_done", 64'(s_done), 64'd0);

    // -1 signed
    run_conv(1'b0, 32'hFFFF_FFFF, dc);
    check("m1_cycle", 64'(dc),     64'd33);
    check("m1_bcd",   64'(s_bcd),  64'h1);
    check("m1_neg",   64'(s_neg),  64'd1);
    check("m1_ndig",  64'(s_ndig), 64'd1);

    // -12345
    run_conv(1'b0, 32'hFFFF_CFC7, dc);
    check("m12345_bcd",  64'(s_bcd),  64'h12345);
    check("m12345_neg",  64'(s_neg),  64'd1);
    check("m12345_ndig", 64'(s_ndig), 64'd5);

    // +100000
    run_conv(1'b0, 32'd100000, dc);
    check("p1e5_bcd",  64'(s_bcd),  64'h100000);
    check("p1e5_neg",  64'(s_neg),  64'd0);
    check("p1e5_ndig", 64'(s_ndig), 64'd6);

    // Most negative value
    run_conv(1'b0, 32'h8000_0000, dc);
    check("min_cycle", 64'(dc),     64'd33);
    check("min_bcd",   64'(s_bcd),  64'h21_4748_3648);
    check("min_neg",   64'(s_neg),  64'd1);
    check("min_ndig",  64'(s_ndig), 64'd10);
    repeat (5) @(negedge clk);
    check("hold_bcd",  64'(s_bcd),  64'h21_4748_3648);
    check("hold_ndig", 64'(s_ndig), 64'd10);
    check("hold_done", 64'(s_done), 64'd0);

    // Unsigned all-ones
    run_conv(1'b1, 32'hFFFF_FFFF, dc);
    check("u_cycle", 64'(dc),     64'd33);
    check("u_bcd",   64'(u_bcd),  64'h42_9496_7295);
    check("u_neg",   64'(u_neg),  64'd0);
    check("u_ndig",  64'(u_ndig), 64'd10);

    // 255 with start re-pulsed during busy (cycle 5) and in the done cycle
    s_start = 1'b1; s_value = 32'd255;
    @(negedge clk);
    s_start = 1'b0;
    n_done = 0; done_at = -1;
    for (int c = 1; c <= 80; c++) begin
      if (s_done === 1'b1) begin
        n_done++;
        if (done_at < 0) done_at = c;
      end
      s_start = (c == 4 || c == 33);
      s_value = (c == 4) ? 32'd99 : 32'd7;
      @(negedge clk);
    end
    s_start = 1'b0;
    check("ign_dones",  64'(n_done),  64'd1);
    check("ign_cycle",  64'(done_at), 64'd33);
    check("ign_bcd",    64'(s_bcd),   64'h255);
    check("ign_ndig",   64'(s_ndig),  64'd3);

    // Reset mid-conversion, together with a new start
    s_start = 1'b1; s_value = 32'd255;
    @(negedge clk);
    s_start = 1'b0;
    n_done = 0; busy_after = 0;
    for (int c = 1; c <= 80; c++) begin
      if (s_done === 1'b1) n_done++;
      if (c >= 10 && s_busy !== 1'b0) busy_after++;
      if (c == 9)  begin s_start = 1'b1; s_value = 32'd7; reset = 1'b1; end
      if (c == 10) begin
        s_start = 1'b0; reset = 1'b0;
        check("ab_bcd",  64'(s_bcd),  64'd0);
        check("ab_ndig", 64'(s_ndig), 64'd1);
        check("ab_neg",  64'(s_neg),  64'd0);
      end
      @(negedge clk);
    end
    check("ab_dones", 64'(n_done),     64'd0);
    check("ab_busy",  64'(busy_after), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_result_bcd_converter
